// File: rtl/regfile_issue_if.sv
// Issue-stage bus: dispatch-side issue group, execute-side operand group and write-back.
// master drives the stage (dispatch/execute/write-back side), slave is the stage itself.
interface regfile_issue_if #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned BID_W    = 4,
  parameter int unsigned IMM_W    = 16
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic                    in_vld;
  logic                    in_rdy;
  logic [LANES-1:0]        in_lane_vld;
  logic [LANES*OP_W-1:0]   in_op;
  logic [LANES*BID_W-1:0]  in_bid;
  logic [LANES*IMM_W-1:0]  in_ime;
  logic [LANES*AW-1:0]     in_des;
  logic [LANES*AW-1:0]     in_s1;
  logic [LANES*AW-1:0]     in_s2;

  logic                    out_vld;
  logic                    out_rdy;
  logic [LANES-1:0]        out_lane_vld;
  logic [LANES*OP_W-1:0]   out_op;
  logic [LANES*BID_W-1:0]  out_bid;
  logic [LANES*IMM_W-1:0]  out_ime;
  logic [LANES*AW-1:0]     out_des;
  logic [LANES*DATA_W-1:0] out_s1_data;
  logic [LANES*DATA_W-1:0] out_s2_data;

  logic [LANES-1:0]        back_vld;
  logic [LANES*AW-1:0]     back_des;
  logic [LANES*DATA_W-1:0] back_data;
  logic                    wb_conflict;

  modport master (
    output in_vld, in_lane_vld, in_op, in_bid, in_ime, in_des, in_s1, in_s2,
    output out_rdy, back_vld, back_des, back_data,
    input  in_rdy, out_vld, out_lane_vld, out_op, out_bid, out_ime, out_des,
    input  out_s1_data, out_s2_data, wb_conflict
  );

  modport slave (
    input  in_vld, in_lane_vld, in_op, in_bid, in_ime, in_des, in_s1, in_s2,
    input  out_rdy, back_vld, back_des, back_data,
    output in_rdy, out_vld, out_lane_vld, out_op, out_bid, out_ime, out_des,
    output out_s1_data, out_s2_data, wb_conflict
  );
endinterface

// File: rtl/regfile_issue_stage.sv
// Multi-lane register-read stage: NUM_REGS x DATA_W file with r0 = 0, write-first bypass,
// valid/ready output register whose held operands track write-backs while stalled.
module regfile_issue_stage #(
  parameter int unsigned LANES    = 4,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned OP_W     = 4,
  parameter int unsigned BID_W    = 4,
  parameter int unsigned IMM_W    = 16,
  parameter logic [(2**OP_W)-1:0] S2_ZERO_MASK = 16'h0014
) (
  input  logic            clk,
  input  logic            rst,
  regfile_issue_if.slave  bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic [DATA_W-1:0]   regs    [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic [DATA_W-1:0]   wr_data [NUM_REGS];
  logic                conflict_c;

  logic [AW-1:0]       held_s1 [LANES];
  logic [AW-1:0]       held_s2 [LANES];
  logic [LANES-1:0]    held_m2;

  logic [DATA_W-1:0]   rd_s1 [LANES];
  logic [DATA_W-1:0]   rd_s2 [LANES];
  logic [LANES-1:0]    m2_c;
  logic [LANES-1:0]    rf_s1_en;
  logic [LANES-1:0]    rf_s2_en;

  logic                load;
  logic                stall;

  assign bus.in_rdy = !bus.out_vld || bus.out_rdy;
  assign load       = bus.in_vld && bus.in_rdy;
  assign stall      = bus.out_vld && !bus.out_rdy;

  // Per-register write select: lowest matching lane wins, any further match is a collision
  always_comb begin
    wr_en      = '0;
    conflict_c = 1'b0;
    for (int r = 0; r < int'(NUM_REGS); r++) wr_data[r] = '0;
    for (int r = 1; r < int'(NUM_REGS); r++) begin
      for (int j = 0; j < int'(LANES); j++) begin
        if (bus.back_vld[j] && (bus.back_des[j*AW +: AW] == AW'(r))) begin
          if (wr_en[r]) begin
            conflict_c = 1'b1;
          end else begin
            wr_en[r]   = 1'b1;
            wr_data[r] = bus.back_data[j*DATA_W +: DATA_W];
          end
        end
      end
    end
  end

  // Operand reads: wr_en[0] is never set and regs[0] is never written, so r0 reads 0
  always_comb begin
    for (int i = 0; i < int'(LANES); i++) begin
      m2_c[i]  = S2_ZERO_MASK[bus.in_op[i*OP_W +: OP_W]];
      rd_s1[i] = wr_en[bus.in_s1[i*AW +: AW]] ? wr_data[bus.in_s1[i*AW +: AW]]
                                               : regs[bus.in_s1[i*AW +: AW]];
      rd_s2[i] = m2_c[i] ? '0
               : (wr_en[bus.in_s2[i*AW +: AW]] ? wr_data[bus.in_s2[i*AW +: AW]]
                                                : regs[bus.in_s2[i*AW +: AW]]);
      rf_s1_en[i] = wr_en[held_s1[i]];
      rf_s2_en[i] = wr_en[held_s2[i]] && !held_m2[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) regs[r] <= '0;
    end else begin
      for (int r = 1; r < int'(NUM_REGS); r++) begin
        if (wr_en[r]) regs[r] <= wr_data[r];
      end
    end
  end

  // Output register: load, refresh held operands while stalled, or drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_vld      <= 1'b0;
      bus.out_lane_vld <= '0;
      bus.out_op       <= '0;
      bus.out_bid      <= '0;
      bus.out_ime      <= '0;
      bus.out_des      <= '0;
      bus.out_s1_data  <= '0;
      bus.out_s2_data  <= '0;
      bus.wb_conflict  <= 1'b0;
      held_m2          <= '0;
      for (int i = 0; i < int'(LANES); i++) begin
        held_s1[i] <= '0;
        held_s2[i] <= '0;
      end
    end else begin
      bus.wb_conflict <= conflict_c;
      if (load) begin
        bus.out_vld      <= 1'b1;
        bus.out_lane_vld <= bus.in_lane_vld;
        bus.out_op       <= bus.in_op;
        bus.out_bid      <= bus.in_bid;
        bus.out_ime      <= bus.in_ime;
        bus.out_des      <= bus.in_des;
        held_m2          <= m2_c;
        for (int i = 0; i < int'(LANES); i++) begin
          held_s1[i] <= bus.in_s1[i*AW +: AW];
          held_s2[i] <= bus.in_s2[i*AW +: AW];
          bus.out_s1_data[i*DATA_W +: DATA_W] <= rd_s1[i];
          bus.out_s2_data[i*DATA_W +: DATA_W] <= rd_s2[i];
        end
      end else if (stall) begin
        for (int i = 0; i < int'(LANES); i++) begin
          if (rf_s1_en[i]) bus.out_s1_data[i*DATA_W +: DATA_W] <= wr_data[held_s1[i]];
          if (rf_s2_en[i]) bus.out_s2_data[i*DATA_W +: DATA_W] <= wr_data[held_s2[i]];
        end
      end else if (bus.out_rdy) begin
        bus.out_vld <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_issue_stage.sv
// Bench for regfile_issue_stage: directed scenarios plus random traffic, all outputs
// compared every cycle against an array-based reference of the register file and issue slot.
module tb_regfile_issue_stage;
  localparam int LANES = 4;
  localparam int NR    = 16;
  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam logic [15:0] MASK = 16'h0014;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_issue_if #(.LANES(LANES), .NUM_REGS(NR), .DATA_W(DW), .OP_W(4), .BID_W(4), .IMM_W(16)) bus ();

  regfile_issue_stage #(.LANES(LANES), .NUM_REGS(NR), .DATA_W(DW), .OP_W(4), .BID_W(4),
                        .IMM_W(16), .S2_ZERO_MASK(16'h0014)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic [DW-1:0]       mregs [NR];
  logic                m_vld, m_conf;
  logic [LANES-1:0]    m_lvld;
  logic [15:0]         m_op, m_bid, m_des;
  logic [63:0]         m_ime;
  logic [LANES*DW-1:0] m_s1, m_s2;
  int                  h1 [LANES];
  int                  h2 [LANES];
  bit                  hm [LANES];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit wb_hit(input int a);
    for (int j = 0; j < LANES; j++)
      if (bus.back_vld[j] && int'(bus.back_des[j*AW +: AW]) == a) return 1'b1;
    return 1'b0;
  endfunction

  // Architectural read: r0 is zero, otherwise lowest write-back lane first, else the file
  function automatic logic [DW-1:0] mread(input int a);
    if (a == 0) return '0;
    for (int j = 0; j < LANES; j++)
      if (bus.back_vld[j] && int'(bus.back_des[j*AW +: AW]) == a)
        return bus.back_data[j*DW +: DW];
    return mregs[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NR; r++) mregs[r] = '0;
    m_vld = 0; m_conf = 0; m_lvld = '0; m_op = '0; m_bid = '0; m_des = '0; m_ime = '0;
    m_s1 = '0; m_s2 = '0;
    for (int i = 0; i < LANES; i++) begin h1[i] = 0; h2[i] = 0; hm[i] = 0; end
  endtask

  task automatic model_step();
    bit ld;
    int cnt;
    ld = bus.in_vld && (!m_vld || bus.out_rdy);
    if (ld) begin
      m_vld = 1; m_lvld = bus.in_lane_vld; m_op = bus.in_op; m_bid = bus.in_bid;
      m_ime = bus.in_ime; m_des = bus.in_des;
      for (int i = 0; i < LANES; i++) begin
        h1[i] = int'(bus.in_s1[i*AW +: AW]);
        h2[i] = int'(bus.in_s2[i*AW +: AW]);
        hm[i] = MASK[int'(bus.in_op[i*4 +: 4])];
        m_s1[i*DW +: DW] = mread(h1[i]);
        m_s2[i*DW +: DW] = hm[i] ? '0 : mread(h2[i]);
      end
    end else if (m_vld && !bus.out_rdy) begin
      for (int i = 0; i < LANES; i++) begin
        if (h1[i] != 0 && wb_hit(h1[i])) m_s1[i*DW +: DW] = mread(h1[i]);
        if (!hm[i] && h2[i] != 0 && wb_hit(h2[i])) m_s2[i*DW +: DW] = mread(h2[i]);
      end
    end else if (bus.out_rdy) begin
      m_vld = 0;
    end
    m_conf = 0;
    for (int r = 1; r < NR; r++) begin
      cnt = 0;
      for (int j = 0; j < LANES; j++)
        if (bus.back_vld[j] && int'(bus.back_des[j*AW +: AW]) == r) cnt++;
      if (cnt > 1) m_conf = 1;
    end
    for (int r = 1; r < NR; r++) mregs[r] = mread(r);
  endtask

  task automatic check_outputs();
    chk("out_vld", bus.out_vld, m_vld);
    chk("out_lane_vld", bus.out_lane_vld, m_lvld);
    chk("out_op", bus.out_op, m_op);
    chk("out_bid", bus.out_bid, m_bid);
    chk("out_ime", bus.out_ime, m_ime);
    chk("out_des", bus.out_des, m_des);
    chk("out_s1_data", bus.out_s1_data, m_s1);
    chk("out_s2_data", bus.out_s2_data, m_s2);
    chk("wb_conflict", bus.wb_conflict, m_conf);
  endtask

  // Inputs are driven just after a posedge; this advances one clock and compares
  task automatic cycle();
    #1;
    chk("in_rdy", bus.in_rdy, !m_vld || bus.out_rdy);
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    bus.in_vld = 0; bus.in_lane_vld = '0; bus.in_op = '0; bus.in_bid = '0; bus.in_ime = '0;
    bus.in_des = '0; bus.in_s1 = '0; bus.in_s2 = '0; bus.out_rdy = 1;
    bus.back_vld = '0; bus.back_des = '0; bus.back_data = '0;
  endtask

  initial begin
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 0;
    #1 chk("rst_in_rdy", bus.in_rdy, 1'b1);

    // Write r3, then read it on lane1
    idle(); bus.back_vld[0] = 1; bus.back_des[0 +: AW] = 4'd3; bus.back_data[0 +: DW] = 32'hDEAD_BEEF;
    cycle();
    idle(); bus.in_vld = 1; bus.in_lane_vld = 4'b0010; bus.in_s1[1*AW +: AW] = 4'd3;
    cycle();
    chk("t1_s1", bus.out_s1_data[1*DW +: DW], 32'hDEAD_BEEF);
    chk("t1_s2", bus.out_s2_data[1*DW +: DW], 32'h0);
    chk("t1_vld", bus.out_vld, 1'b1);

    // Same-cycle bypass, then the stored value
    idle(); bus.back_vld[2] = 1; bus.back_des[2*AW +: AW] = 4'd5; bus.back_data[2*DW +: DW] = 32'h1234;
    bus.in_vld = 1; bus.in_lane_vld = 4'b0001; bus.in_s1[0 +: AW] = 4'd5;
    cycle();
    chk("byp_s1", bus.out_s1_data[0 +: DW], 32'h1234);
    idle(); bus.in_vld = 1; bus.in_s1[3*AW +: AW] = 4'd5;
    cycle();
    chk("byp_later", bus.out_s1_data[3*DW +: DW], 32'h1234);

    // Write collision on r7, then on r0
    idle(); bus.back_vld = 4'b1010;
    bus.back_des[1*AW +: AW] = 4'd7; bus.back_data[1*DW +: DW] = 32'hAAAA;
    bus.back_des[3*AW +: AW] = 4'd7; bus.back_data[3*DW +: DW] = 32'hBBBB;
    cycle();
    chk("conf_r7", bus.wb_conflict, 1'b1);
    idle(); bus.in_vld = 1; bus.in_s1[0 +: AW] = 4'd7;
    cycle();
    chk("conf_pulse", bus.wb_conflict, 1'b0);
    chk("conf_r7_val", bus.out_s1_data[0 +: DW], 32'hAAAA);
    idle(); bus.back_vld = 4'b1010; bus.back_data = {4{32'h5A5A_5A5A}};
    cycle();
    chk("conf_r0", bus.wb_conflict, 1'b0);
    idle(); bus.in_vld = 1;
    cycle();
    chk("r0_zero", bus.out_s1_data[0 +: DW], 32'h0);

    // s2 masking by opcode
    idle(); bus.in_vld = 1; bus.in_lane_vld = 4'hF; bus.in_s2 = 16'h3333; bus.in_op = 16'h4444;
    cycle();
    chk("mask_op4", bus.out_s2_data, 128'h0);
    bus.in_op = 16'h2222;
    cycle();
    chk("mask_op2", bus.out_s2_data, 128'h0);
    bus.in_op = 16'h1111;
    cycle();
    chk("mask_op1", bus.out_s2_data, {4{32'hDEAD_BEEF}});

    // Stall with operand refresh, then release with back-to-back load
    idle(); bus.back_vld[0] = 1; bus.back_des[0 +: AW] = 4'd9; bus.back_data[0 +: DW] = 32'h1;
    cycle();
    idle(); bus.in_vld = 1; bus.in_lane_vld = 4'hF; bus.in_s1[0 +: AW] = 4'd9; bus.in_op = 16'h0003;
    cycle();
    chk("stall_load", bus.out_s1_data[0 +: DW], 32'h1);
    idle(); bus.in_vld = 1; bus.in_op = 16'hFFFF; bus.in_s1[0 +: AW] = 4'd9; bus.out_rdy = 0;
    bus.back_vld = 4'b0101;
    bus.back_des[0 +: AW] = 4'd9; bus.back_data[0 +: DW] = 32'h55;
    bus.back_des[2*AW +: AW] = 4'd9; bus.back_data[2*DW +: DW] = 32'h66;
    cycle();
    chk("stall_rdy", bus.in_rdy, 1'b0);
    chk("stall_refresh", bus.out_s1_data[0 +: DW], 32'h55);
    chk("stall_side", bus.out_op, 16'h0003);
    bus.back_vld = '0; bus.out_rdy = 1;
    cycle();
    chk("release_vld", bus.out_vld, 1'b1);
    chk("release_op", bus.out_op, 16'hFFFF);
    chk("release_s1", bus.out_s1_data[0 +: DW], 32'h55);

    // Asynchronous reset in the middle of a stall
    bus.out_rdy = 0; bus.back_vld = 4'b0011;
    bus.back_des[0 +: AW] = 4'd4; bus.back_des[1*AW +: AW] = 4'd4;
    cycle();
    chk("pre_rst_conf", bus.wb_conflict, 1'b1);
    #2 rst = 1;
    #1;
    model_reset();
    chk("arst_vld", bus.out_vld, 1'b0);
    chk("arst_conf", bus.wb_conflict, 1'b0);
    chk("arst_s1", bus.out_s1_data, 128'h0);
    #1 rst = 0;
    #1 chk("arst_in_rdy", bus.in_rdy, 1'b1);
    @(posedge clk); #1;
    idle(); bus.in_vld = 1; bus.in_s1 = 16'h3999; bus.in_s2 = 16'h0007;
    cycle();
    chk("arst_regs", bus.out_s1_data, 128'h0);

    // Random traffic against the reference
    for (int n = 0; n < 400; n++) begin
      bus.in_vld      = ($urandom_range(0, 9) < 8);
      bus.in_lane_vld = 4'($urandom);
      bus.in_op       = 16'($urandom);
      bus.in_bid      = 16'($urandom);
      bus.in_ime      = {$urandom, $urandom};
      bus.in_des      = 16'($urandom);
      bus.in_s1       = 16'($urandom);
      bus.in_s2       = 16'($urandom);
      bus.out_rdy     = ($urandom_range(0, 3) != 0);
      bus.back_vld    = 4'($urandom);
      for (int j = 0; j < LANES; j++) bus.back_des[j*AW +: AW] = 4'($urandom_range(0, 7));
      bus.back_data   = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
